// File: rtl/ahb_sram_slave_p.sv
// ahb_sram_slave_p: AHB-Lite SRAM slave with configurable wait states,
// byte-lane writes and a saturating error-response counter.
module ahb_sram_slave_p #(
  parameter int          DATA_W      = 32,
  parameter int          MEM_BYTES   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADYIN,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [7:0]        ERR_CNT
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(LB);
  localparam logic [2:0] WS_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_OKAY, S_ERR1, S_ERR2
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [2:0]    cnt;
  logic          accept;
  logic          addr_err;
  logic [2:0]    amask;
  logic [2:0]    smask;
  logic [NB-1:0] be;
  logic [AW-1:0] word_base;
  logic          unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  // Only a ready slave can take a new address phase
  assign accept = HREADYOUT & HSEL & HREADYIN & HTRANS[1];

  always_comb begin
    amask = 3'b111;
    unique case (HSIZE)
      3'd0:    amask = 3'b000;
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  assign addr_err = (HADDR[31:AW] != BASE_ADDR[31:AW])
                  | (HSIZE > MAX_SIZE)
                  | ((HADDR[2:0] & amask) != 3'b000);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT: if (cnt == 3'd0) state_nx = S_OKAY;
      S_ERR1: state_nx = S_ERR2;
      default: begin
        if (!accept)               state_nx = S_IDLE;
        else if (addr_err)         state_nx = S_ERR1;
        else if (WAIT_STATES == 0) state_nx = S_OKAY;
        else                       state_nx = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      cnt     <= 3'd0;
    end else begin
      if (accept) begin
        addr_q  <= HADDR[AW-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
        cnt     <= WS_LOAD;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      ERR_CNT <= 8'd0;
    else if (state == S_ERR2 && ERR_CNT != 8'hFF)
      ERR_CNT <= ERR_CNT + 8'd1;
  end

  always_comb begin
    smask = 3'b111;
    unique case (size_q)
      3'd0:    smask = 3'b000;
      3'd1:    smask = 3'b001;
      3'd2:    smask = 3'b011;
      default: smask = 3'b111;
    endcase
  end

  // A lane is enabled when it shares the access's bits above the size
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      be[i] = ((LB'(i) ^ addr_q[LB-1:0]) & ~smask[LB-1:0]) == '0;
  end

  assign word_base = addr_q & ~AW'(NB - 1);

  always_ff @(posedge HCLK) begin
    if (HRESETn && state == S_OKAY && write_q) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[word_base + AW'(i)] <= HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    unique case (state)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      S_OKAY: begin
        if (!write_q) begin
          for (int i = 0; i < NB; i++)
            if (be[i]) HRDATA[8*i +: 8] = mem[word_base + AW'(i)];
        end
      end
      default: ;
    endcase
  end
endmodule

// File: doc/ahb_sram_slave_p.md
AHB_SRAM_SLAVE_P -- requirements
Module: ahb_sram_slave_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, meaning memory size in bytes; it is a power of 2 and at least DATA_W/8.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first byte address of the region, aligned to MEM_BYTES.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning extra HREADYOUT-low cycles per OKAY transfer; legal range 0..7.
REQ-005 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port HSEL, input, 1 bit: slave select from the decoder.
REQ-008 SHALL have port HADDR, input, 32 bits: byte address.
REQ-009 SHALL have port HTRANS, input, 2 bits: transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-010 SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port HSIZE, input, 3 bits: transfer size of 2^HSIZE bytes.
REQ-012 SHALL have port HBURST, input, 3 bits: burst type; accepted and ignored, because each beat carries its own HADDR.
REQ-013 SHALL have port HWDATA, input, DATA_W bits: write data, valid in the data phase.
REQ-014 SHALL have port HREADYIN, input, 1 bit: bus HREADY from the mux.
REQ-015 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-016 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-017 SHALL have port HRDATA, output, DATA_W bits: read data.
REQ-018 SHALL have port ERR_CNT, output, 8 bits: saturating count of ERROR responses issued.

Function
REQ-019 SHALL accept an address phase only when HSEL=1, HREADYIN=1 and HTRANS[1]=1; at that edge it registers the address, the write flag, HSIZE and an error flag.
REQ-020 SHALL set the error flag when any of these holds: HADDR is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES-1]; 2^HSIZE > DATA_W/8; HADDR is not aligned to 2^HSIZE.
REQ-021 SHALL treat HTRANS IDLE/BUSY, HSEL=0, or HREADYIN=0 as no transfer; the next data phase is then zero-wait OKAY with no memory access.
REQ-022 SHALL run an FSM with states IDLE, WAIT, OKAY_DONE, ERR1, ERR2.
REQ-023 SHALL move from IDLE on an accepted transfer as follows: error -> ERR1; WAIT_STATES=0 -> OKAY_DONE; otherwise -> WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-024 SHALL, in WAIT, drive HREADYOUT=0 and HRESP=0, decrement the counter, and go to OKAY_DONE when the counter reaches 0.
REQ-025 SHALL, in OKAY_DONE, drive HREADYOUT=1 and HRESP=0, complete the data phase, and return to IDLE or accept a pipelined next transfer in the same cycle.
REQ-026 SHALL, in ERR1, drive HREADYOUT=0 and HRESP=1; ERR2 follows unconditionally.
REQ-027 SHALL, in ERR2, drive HREADYOUT=1 and HRESP=1 and increment ERR_CNT (saturating at 255).
REQ-028 SHALL commit a write to memory at the edge ending its OKAY_DONE cycle, writing only bytes addr..addr+2^HSIZE-1 from lane (addr mod DATA_W/8) of HWDATA.
REQ-029 SHALL drive HRDATA for a read during OKAY_DONE only, as the memory bytes in their natural lanes with non-addressed lanes 0.
REQ-030 SHALL drive HRDATA to 0 in all other states and for writes.
REQ-031 SHALL return, for a read issued immediately after a write to the same address, the newly written data (write-then-read in back-to-back pipelined beats).
REQ-032 SHALL support pipelining: the address phase of beat N+1 is accepted in the same cycle as beat N's final (HREADYOUT=1) data-phase cycle.
REQ-033 SHALL never write memory for an ERROR transfer.
REQ-034 SHALL ignore the HTRANS value of a transfer already accepted; a BUSY received mid-burst does not alter an in-flight data phase.

Reset
REQ-035 SHALL, while HRESETn=0 at a clock edge, force the FSM to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, ERR_CNT=0 and clear the registered address-phase state.
REQ-036 SHALL discard an in-flight write if reset is asserted before its commit edge.
REQ-037 SHALL leave memory contents unchanged by reset.

Verification
REQ-038 SHALL pass this scenario: DATA_W=32, WAIT_STATES=0, word write 32'h3424_2343 to BASE+0x34, then read BASE+0x34 back-to-back -> HRDATA=32'h3424_2343 in the read data phase, no HREADYOUT=0 cycles.
REQ-039 SHALL pass this scenario: WAIT_STATES=3, NONSEQ read -> HREADYOUT low for exactly 3 cycles, then high with data.
REQ-040 SHALL pass this scenario: halfword write 16'h8732 at BASE+0x36 on a 32-bit bus -> bytes 0x36=0x32 and 0x37=0x87, bytes 0x34/0x35 unchanged.
REQ-041 SHALL pass this scenario: read at BASE+MEM_BYTES -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, and ERR_CNT 0->1.
REQ-042 SHALL pass this scenario: word access at BASE+0x02 (misaligned) -> ERROR response and no memory change; 300 such errors -> ERR_CNT=255.
REQ-043 SHALL pass this scenario: INCR4 write with BUSY inserted after beat 2, then reset asserted during a WAIT state -> outputs take reset values next edge and the pending beat is not written.
